// File: rtl/link_tx_scheduler.sv
// Round-robin scheduler for the 32-bit FPGA1->FPGA2 link: one burst per grant,
// sequenced as req -> rdy -> BURST_LEN words -> ack -> release, with wait timeouts.
module link_tx_scheduler #(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned BURST_LEN      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_req,
    input  logic [32*NUM_SRC-1:0]      src_data,
    output logic [NUM_SRC-1:0]         src_pop,
    output logic [31:0]                link_data,
    output logic                       link_req,
    input  logic                       link_rdy,
    input  logic                       link_ack,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned ID_W  = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_WAIT,
        S_SEND,
        S_ACK_WAIT,
        S_RELEASE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              rdy_meta;
    logic              rdy_s;
    logic              ack_meta;
    logic              ack_s;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   arb_sel;
    logic              arb_found;
    logic [CNT_W-1:0]  word_cnt;
    logic [TMR_W-1:0]  tmr;
    logic              tmr_expired;
    logic              waiting;
    logic              link_req_d;
    logic              timeout_err_d;
    logic [31:0]       src_word [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_word
        assign src_word[i] = src_data[32*i +: 32];
    end

    assign tmr_expired = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
    assign waiting     = (state == S_REQ_WAIT) || (state == S_ACK_WAIT);
    assign busy        = (state != S_IDLE);

    // rdy/ack come from the other FPGA's clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            rdy_meta <= link_rdy;
            rdy_s    <= rdy_meta;
            ack_meta <= link_ack;
            ack_s    <= ack_meta;
        end
    end

    // First requester after the last grant, wrapping around
    always_comb begin
        logic [ID_W-1:0] cand;
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = ID_W'((32'(ptr) + k) % NUM_SRC);
            if (!arb_found && src_req[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (arb_found) state_d = S_REQ_WAIT;
            S_REQ_WAIT: if (rdy_s || tmr_expired) state_d = rdy_s ? S_SEND : S_RELEASE;
            S_SEND:     if (word_cnt == CNT_W'(BURST_LEN - 1)) state_d = S_ACK_WAIT;
            S_ACK_WAIT: if (ack_s || tmr_expired) state_d = S_RELEASE;
            S_RELEASE:  if (!ack_s) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        src_pop       = '0;
        link_req_d    = 1'b0;
        timeout_err_d = 1'b0;
        if (state == S_SEND) src_pop[grant_id] = 1'b1;
        link_req_d    = (state_d == S_REQ_WAIT) || (state_d == S_SEND) || (state_d == S_ACK_WAIT);
        // a completed handshake wins over an expiring timer in the same cycle
        timeout_err_d = (state == S_REQ_WAIT && state_d == S_RELEASE) ||
                        (state == S_ACK_WAIT && state_d == S_RELEASE && !ack_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_req    <= 1'b0;
            link_data   <= '0;
            grant_id    <= '0;
            ptr         <= ID_W'(NUM_SRC - 1);
            timeout_err <= 1'b0;
            word_cnt    <= '0;
            tmr         <= '0;
        end else begin
            link_req    <= link_req_d;
            timeout_err <= timeout_err_d;
            if (state == S_IDLE && arb_found) begin
                grant_id <= arb_sel;
                ptr      <= arb_sel;
            end
            if (state == S_SEND) begin
                link_data <= src_word[grant_id];
                word_cnt  <= word_cnt + CNT_W'(1);
            end else begin
                word_cnt  <= '0;
            end
            tmr <= (waiting && state_d == state) ? tmr + TMR_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Randomized bench for link_tx_scheduler: bench-side FIFOs and FPGA2 partner,
// round-robin and handshake timing predicted from the link protocol rules.
module tb_link_tx_scheduler;

    localparam int NUM_SRC   = 4;
    localparam int BURST_LEN = 10;
    localparam int T         = 32;
    localparam int DEPTH     = BURST_LEN + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_SRC-1:0]   src_req;
    logic [32*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_pop;
    logic [31:0]          link_data;
    logic                 link_req;
    logic                 link_rdy;
    logic                 link_ack;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_err;

    link_tx_scheduler #(
        .NUM_SRC(NUM_SRC), .BURST_LEN(BURST_LEN), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data), .src_pop(src_pop),
        .link_data(link_data), .link_req(link_req), .link_rdy(link_rdy), .link_ack(link_ack),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [NUM_SRC][DEPTH];
    int          rd_ptr [NUM_SRC];
    int          cyc = 0;
    int          pop_cnt = 0;
    int          first_pop = -1;
    int          last_pop = -1;
    int          bad_pop = 0;
    int          exp_g = 0;
    int          rr_last = NUM_SRC - 1;
    int          total_pops = 0;
    bit          pend = 1'b0;
    logic [31:0] last_word = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_SRC-1:0] mask);
        for (int k = 1; k <= NUM_SRC; k++) begin
            int i;
            i = (rr_last + k) % NUM_SRC;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive_heads();
        for (int i = 0; i < NUM_SRC; i++)
            src_data[32*i +: 32] = (rd_ptr[i] < DEPTH) ? mem[i][rd_ptr[i]] : 32'h0;
    endtask

    task automatic refill();
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < DEPTH; j++) mem[i][j] = $urandom;
            rd_ptr[i] = 0;
        end
        drive_heads();
    endtask

    // One clock: apply the FIFO pop strobed last cycle, then look at this cycle's pop
    task automatic step();
        logic [31:0] w;
        @(posedge clk);
        #1;
        cyc++;
        if (pend) begin
            w = mem[exp_g][rd_ptr[exp_g]];
            rd_ptr[exp_g]++;
            check("link_data", link_data, w);
            last_word = w;
            drive_heads();
        end
        pend = 1'b0;
        if (src_pop != '0) begin
            if (src_pop != 4'(1 << exp_g)) bad_pop++;
            else pend = 1'b1;
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
        end
    endtask

    task automatic run_burst(input logic [NUM_SRC-1:0] mask, input int rdy_dly, input int ack_dly,
                             input int ack_hold, input bit drop_req);
        int n0, rdy_at, ack_at, req_fall, err_at, err_cnt, d;
        bit to_req, to_ack;
        exp_g   = rr_pick(mask);
        rr_last = exp_g;
        refill();
        pop_cnt = 0; bad_pop = 0; pend = 1'b0; first_pop = -1; last_pop = -1;
        src_req = mask;
        step();
        check("grant_req", 32'(link_req), 32'd1);
        check("grant_id", 32'(grant_id), 32'(exp_g));
        check("grant_busy", 32'(busy), 32'd1);
        if (drop_req) src_req = '0;
        n0 = cyc; rdy_at = -1; ack_at = -1; req_fall = -1; err_at = -1; err_cnt = 0;
        to_req = (rdy_dly < 0) || (rdy_dly > T - 3);
        to_ack = (ack_dly < 0) || (ack_dly > T - 3);
        for (int k = 0; k < BURST_LEN + 2*T + 40 && req_fall < 0; k++) begin
            if (rdy_dly >= 0 && cyc - n0 == rdy_dly) begin link_rdy = 1'b1; rdy_at = cyc; end
            if (pop_cnt == 2) link_rdy = 1'b0;
            if (ack_dly >= 0 && pop_cnt == BURST_LEN && cyc == last_pop + 1 + ack_dly) begin
                link_ack = 1'b1; ack_at = cyc;
            end
            step();
            if (timeout_err) begin err_cnt++; err_at = cyc; end
            if (!link_req) req_fall = cyc;
        end
        link_rdy = 1'b0;
        check("req_fall_seen", 32'(req_fall >= 0), 32'd1);
        if (to_req) begin
            check("req_to_cycles", 32'(req_fall - n0), 32'(T));
            check("req_to_pulse", 32'(err_at - n0), 32'(T));
        end else begin
            check("rdy_to_pop", 32'(first_pop - rdy_at), 32'd3);
            check("pop_contig", 32'(last_pop - first_pop + 1), 32'(BURST_LEN));
            if (to_ack) begin
                check("ack_to_cycles", 32'(req_fall - last_pop), 32'(T + 1));
                check("ack_to_pulse", 32'(err_at - last_pop), 32'(T + 1));
            end else begin
                check("ack_to_req", 32'(req_fall - ack_at), 32'd3);
            end
        end
        check("err_count", 32'(err_cnt), (to_req || to_ack) ? 32'd1 : 32'd0);
        step();
        check("err_width", 32'(timeout_err), 32'd0);
        if (link_ack) begin
            for (int k = 0; k < ack_hold; k++) begin
                check("rel_hold", 32'({busy, link_req}), 32'h2);
                step();
            end
            check("rel_hold", 32'({busy, link_req}), 32'h2);
            link_ack = 1'b0;
            d = cyc;
            for (int k = 0; k < 10 && busy; k++) step();
            check("rel_exit", 32'(cyc - d), 32'd3);
        end else begin
            check("idle_after_to", 32'(busy), 32'd0);
        end
        if (!to_req) check("data_hold", link_data, last_word);
        check("pop_total", 32'(pop_cnt), to_req ? 32'd0 : 32'(BURST_LEN));
        check("pop_target", 32'(bad_pop), 32'd0);
        total_pops += pop_cnt;
    endtask

    task automatic reset_mid_burst();
        exp_g   = rr_pick(4'b0100);
        rr_last = exp_g;
        refill();
        pop_cnt = 0; bad_pop = 0; pend = 1'b0; first_pop = -1; last_pop = -1;
        src_req = 4'b0100;
        step();
        check("rst_grant", 32'(grant_id), 32'(exp_g));
        link_rdy = 1'b1;
        for (int k = 0; k < 40 && pop_cnt < 4; k++) step();
        check("rst_pops", 32'(pop_cnt), 32'd4);
        rst  = 1'b1;
        pend = 1'b0;
        step();
        check("rst_link_req", 32'(link_req), 32'd0);
        check("rst_link_data", link_data, 32'd0);
        check("rst_src_pop", 32'(src_pop), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; link_rdy = 1'b0; src_req = '0;
        rr_last = NUM_SRC - 1;
        step();
        step();
        check("rst_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd, ad;
        rst = 1'b1; src_req = '0; link_rdy = 1'b0; link_ack = 1'b0; src_data = '0;
        for (int i = 0; i < NUM_SRC; i++) rd_ptr[i] = DEPTH;
        repeat (3) step();
        check("reset_link_req", 32'(link_req), 32'd0);
        check("reset_link_data", link_data, 32'd0);
        check("reset_src_pop", 32'(src_pop), 32'd0);
        check("reset_grant_id", 32'(grant_id), 32'd0);
        check("reset_timeout", 32'(timeout_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        run_burst(4'b0100, 5, 3, 2, 1'b0);
        total_pops = 0;
        for (int b = 0; b < 8; b++)
            run_burst(4'b1111, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), 1'b0);
        check("pops_8_bursts", 32'(total_pops), 32'(8 * BURST_LEN));
        run_burst(4'b0001, -1, 0, 0, 1'b1);
        run_burst(4'b0010, 2, 1, 20, 1'b0);
        run_burst(4'b0010, 1, 0, 0, 1'b1);
        run_burst(4'b0100, T - 3, 0, 0, 1'b1);
        run_burst(4'b0100, T - 2, 0, 0, 1'b1);
        run_burst(4'b1000, 0, T - 3, 1, 1'b1);
        run_burst(4'b1000, 0, T - 2, 1, 1'b1);
        run_burst(4'b0001, 0, -1, 0, 1'b1);
        run_burst(4'b0001, 1, 1, 0, 1'b1);
        run_burst(4'b1001, 1, 1, 0, 1'b0);
        run_burst(4'b1001, 1, 1, 0, 1'b1);
        reset_mid_burst();
        run_burst(4'b0011, 0, 0, 0, 1'b1);
        run_burst(4'b0010, 0, 0, 0, 1'b1);

        for (int r = 0; r < 25; r++) begin
            rd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            ad = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            run_burst(4'($urandom_range(1, 15)), rd, ad, int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
